// File: rtl/fp_tiny_pkg.sv
// Shared widths, FSM state encoding and small helpers for the tiny
// floating-point align/add datapath.
package fp_tiny_pkg;

    localparam int EXP_W  = 3;
    localparam int FRAC_W = 4;
    localparam int MANT_W = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } fsm_state_t;

    // Alignment shift count, saturated so large differences cost a bounded number of cycles.
    function automatic logic [EXP_W-1:0] sat_shift(input logic [EXP_W-1:0] diff,
                                                   input logic [EXP_W-1:0] max_shift);
        logic [EXP_W-1:0] res;
        if (diff > max_shift) begin
            res = max_shift;
        end else begin
            res = diff;
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_mant_addsub.sv
// Combinational mantissa adder/subtractor; one extra result bit holds the carry.
module fp_mant_addsub
    import fp_tiny_pkg::*;
(
    input  logic [MANT_W-1:0] a,
    input  logic [MANT_W-1:0] b,
    input  logic              sub,
    output logic [MANT_W:0]   y
);

    // Magnitude add, or big-minus-small when the operand signs differ.
    always_comb begin
        y = {(MANT_W+1){1'b0}};
        if (sub) begin
            y = {1'b0, a} - {1'b0, b};
        end else begin
            y = {1'b0, a} + {1'b0, b};
        end
    end

endmodule

// File: rtl/fp_align_add.sv
// Multi-cycle tiny-float adder: serial alignment, one add cycle, serial
// normalisation, then a held result with a valid/ready handshake.
module fp_align_add
    import fp_tiny_pkg::*;
#(
    parameter int MAX_ALIGN = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign_big,
    input  logic              in_sign_small,
    input  logic [EXP_W-1:0]  in_exp_big,
    input  logic [EXP_W-1:0]  in_expdiff,
    input  logic [FRAC_W-1:0] in_bigfract,
    input  logic [FRAC_W-1:0] in_smallfract,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_fract,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              out_zero
);

    localparam logic [EXP_W-1:0] MAX_ALIGN_C = EXP_W'(MAX_ALIGN);
    localparam logic [EXP_W-1:0] EXP_MAX_C   = {EXP_W{1'b1}};

    fsm_state_t        state_r;
    logic [EXP_W-1:0]  cnt_r;
    logic              sign_big_r;
    logic              sub_r;
    logic [EXP_W-1:0]  exp_r;
    logic [MANT_W-1:0] mbig_r;
    logic [MANT_W-1:0] msmall_r;
    logic [MANT_W:0]   sum_r;
    logic              res_sign_r;
    logic              ovf_r;
    logic              unf_r;
    logic              zero_r;
    logic [MANT_W:0]   sum_s;

    fp_mant_addsub u_addsub (
        .a   (mbig_r),
        .b   (msmall_r),
        .sub (sub_r),
        .y   (sum_s)
    );

    // Control FSM, working datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {EXP_W{1'b0}};
            sign_big_r <= 1'b0;
            sub_r      <= 1'b0;
            exp_r      <= {EXP_W{1'b0}};
            mbig_r     <= {MANT_W{1'b0}};
            msmall_r   <= {MANT_W{1'b0}};
            sum_r      <= {(MANT_W+1){1'b0}};
            res_sign_r <= 1'b0;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
            zero_r     <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_sign   <= 1'b0;
            out_exp    <= {EXP_W{1'b0}};
            out_fract  <= {FRAC_W{1'b0}};
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
            out_zero   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready   <= 1'b0;
                        sign_big_r <= in_sign_big;
                        sub_r      <= in_sign_big ^ in_sign_small;
                        exp_r      <= in_exp_big;
                        mbig_r     <= {1'b1, in_bigfract};
                        msmall_r   <= {1'b1, in_smallfract};
                        cnt_r      <= sat_shift(in_expdiff, MAX_ALIGN_C);
                        ovf_r      <= 1'b0;
                        unf_r      <= 1'b0;
                        zero_r     <= 1'b0;
                        if (in_expdiff != {EXP_W{1'b0}}) begin
                            state_r <= ALIGN;
                        end else begin
                            state_r <= ADD;
                        end
                    end
                end
                ALIGN: begin
                    msmall_r <= {1'b0, msmall_r[MANT_W-1:1]};
                    cnt_r    <= cnt_r - {{(EXP_W-1){1'b0}}, 1'b1};
                    if (cnt_r <= {{(EXP_W-1){1'b0}}, 1'b1}) begin
                        state_r <= ADD;
                    end
                end
                ADD: begin
                    sum_r      <= sum_s;
                    res_sign_r <= sign_big_r;
                    state_r    <= NORM;
                end
                NORM: begin
                    // One normalisation decision per cycle, carry first.
                    if (sum_r[MANT_W]) begin
                        if (exp_r == EXP_MAX_C) begin
                            sum_r <= {1'b0, {MANT_W{1'b1}}};
                            ovf_r <= 1'b1;
                        end else begin
                            sum_r <= {1'b0, sum_r[MANT_W:1]};
                            exp_r <= exp_r + {{(EXP_W-1){1'b0}}, 1'b1};
                        end
                        state_r <= DONE;
                    end else if (sum_r == {(MANT_W+1){1'b0}}) begin
                        exp_r      <= {EXP_W{1'b0}};
                        res_sign_r <= 1'b0;
                        zero_r     <= 1'b1;
                        state_r    <= DONE;
                    end else if (sum_r[MANT_W-1]) begin
                        state_r <= DONE;
                    end else if (exp_r == {EXP_W{1'b0}}) begin
                        sum_r      <= {(MANT_W+1){1'b0}};
                        res_sign_r <= 1'b0;
                        unf_r      <= 1'b1;
                        zero_r     <= 1'b1;
                        state_r    <= DONE;
                    end else begin
                        sum_r <= {sum_r[MANT_W-1:0], 1'b0};
                        exp_r <= exp_r - {{(EXP_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; it then holds until consumed.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_sign  <= res_sign_r;
                        out_exp   <= exp_r;
                        out_fract <= sum_r[FRAC_W-1:0];
                        out_ovf   <= ovf_r;
                        out_unf   <= unf_r;
                        out_zero  <= zero_r;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_align_add.sv
// Directed self-checking bench for fp_align_add.
module tb_fp_align_add;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_sign_big;
    logic       in_sign_small;
    logic [2:0] in_exp_big;
    logic [2:0] in_expdiff;
    logic [3:0] in_bigfract;
    logic [3:0] in_smallfract;
    logic       out_ready;
    logic       out_valid;
    logic       out_sign;
    logic [2:0] out_exp;
    logic [3:0] out_fract;
    logic       out_ovf;
    logic       out_unf;
    logic       out_zero;

    int checks;
    int errors;

    fp_align_add #(.MAX_ALIGN(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign_big  (in_sign_big),
        .in_sign_small(in_sign_small),
        .in_exp_big   (in_exp_big),
        .in_expdiff   (in_expdiff),
        .in_bigfract  (in_bigfract),
        .in_smallfract(in_smallfract),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_fract    (out_fract),
        .out_ovf      (out_ovf),
        .out_unf      (out_unf),
        .out_zero     (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand set, capture it, and count cycles until out_valid (bounded).
    task automatic run_op(input logic sb, input logic ss, input logic [2:0] eb,
                          input logic [2:0] diff, input logic [3:0] bf, input logic [3:0] sf,
                          output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        in_sign_big = sb; in_sign_small = ss; in_exp_big = eb;
        in_expdiff = diff; in_bigfract = bf; in_smallfract = sf;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        in_sign_big = 1'b0; in_sign_small = 1'b0; in_exp_big = 3'd0;
        in_expdiff = 3'd0; in_bigfract = 4'd0; in_smallfract = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b, required 0", out_valid);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero}
                !== {1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b v=%b s=%b e=%0d f=%b ovf=%b unf=%b z=%b, required rdy=1 rest 0",
                     in_ready, out_valid, out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero);
        end
    endtask

    task automatic test_carry();
        int lat;
        run_op(1'b0, 1'b0, 3'd3, 3'd0, 4'b0000, 4'b0000, lat);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL carry_busy: in_ready=%b, required 0", in_ready);
        end
        checks++;
        if ({out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero, lat}
                !== {1'b0, 3'd4, 4'b0000, 3'b000, 32'd3}) begin
            errors++;
            $display("FAIL carry: s=%b e=%0d f=%b flags=%b%b%b lat=%0d, required s=0 e=4 f=0000 flags=000 lat=3",
                     out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero, lat);
        end
        consume();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL handshake: v=%b rdy=%b, required v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_align();
        int lat;
        run_op(1'b1, 1'b1, 3'd5, 3'd2, 4'b0000, 4'b0000, lat);
        checks++;
        if ({out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero, lat}
                !== {1'b1, 3'd5, 4'b0100, 3'b000, 32'd5}) begin
            errors++;
            $display("FAIL align2: s=%b e=%0d f=%b flags=%b%b%b lat=%0d, required s=1 e=5 f=0100 flags=000 lat=5",
                     out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero, lat);
        end
        consume();
    endtask

    task automatic test_norm_left();
        int lat;
        run_op(1'b1, 1'b0, 3'd2, 3'd0, 4'b1000, 4'b0000, lat);
        checks++;
        if ({out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero, lat}
                !== {1'b1, 3'd1, 4'b0000, 3'b000, 32'd4}) begin
            errors++;
            $display("FAIL norm_left: s=%b e=%0d f=%b flags=%b%b%b lat=%0d, required s=1 e=1 f=0000 flags=000 lat=4",
                     out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero, lat);
        end
        consume();
    endtask

    task automatic test_overflow_zero();
        int lat;
        run_op(1'b0, 1'b0, 3'd7, 3'd0, 4'b1111, 4'b1111, lat);
        checks++;
        if ({out_exp, out_fract, out_ovf, out_unf, out_zero, lat}
                !== {3'd7, 4'b1111, 3'b100, 32'd3}) begin
            errors++;
            $display("FAIL overflow: e=%0d f=%b flags=%b%b%b lat=%0d, required e=7 f=1111 flags=100 lat=3",
                     out_exp, out_fract, out_ovf, out_unf, out_zero, lat);
        end
        consume();
        run_op(1'b1, 1'b0, 3'd3, 3'd0, 4'b0101, 4'b0101, lat);
        checks++;
        if ({out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero, lat}
                !== {1'b0, 3'd0, 4'b0000, 3'b001, 32'd3}) begin
            errors++;
            $display("FAIL exact_zero: s=%b e=%0d f=%b flags=%b%b%b lat=%0d, required s=0 e=0 f=0000 flags=001 lat=3",
                     out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero, lat);
        end
        consume();
    endtask

    task automatic test_underflow();
        int lat;
        run_op(1'b1, 1'b0, 3'd0, 3'd0, 4'b1000, 4'b0000, lat);
        checks++;
        if ({out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero, lat}
                !== {1'b0, 3'd0, 4'b0000, 3'b011, 32'd3}) begin
            errors++;
            $display("FAIL underflow: s=%b e=%0d f=%b flags=%b%b%b lat=%0d, required s=0 e=0 f=0000 flags=011 lat=3",
                     out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero, lat);
        end
        consume();
    endtask

    task automatic test_saturate_hold();
        int lat;
        run_op(1'b0, 1'b0, 3'd6, 3'd7, 4'b1010, 4'b1111, lat);
        checks++;
        if ({out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero, lat}
                !== {1'b0, 3'd6, 4'b1010, 3'b000, 32'd8}) begin
            errors++;
            $display("FAIL saturate: s=%b e=%0d f=%b flags=%b%b%b lat=%0d, required s=0 e=6 f=1010 flags=000 lat=8",
                     out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero, lat);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, out_exp, out_fract} !== {1'b1, 1'b0, 3'd6, 4'b1010}) begin
                errors++;
                $display("FAIL hold%0d: v=%b rdy=%b e=%0d f=%b, required v=1 rdy=0 e=6 f=1010",
                         i, out_valid, in_ready, out_exp, out_fract);
            end
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        in_sign_big = 1'b0; in_sign_small = 1'b0; in_exp_big = 3'd4;
        in_expdiff = 3'd4; in_bigfract = 4'b0001; in_smallfract = 4'b0001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid: valid cycles=%0d rdy=%b, required 0 and 1", seen, in_ready);
        end
        run_op(1'b0, 1'b1, 3'd4, 3'd1, 4'b0000, 4'b0000, lat);
        checks++;
        if ({out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero, lat}
                !== {1'b0, 3'd3, 4'b0000, 3'b000, 32'd5}) begin
            errors++;
            $display("FAIL after_reset: s=%b e=%0d f=%b flags=%b%b%b lat=%0d, required s=0 e=3 f=0000 flags=000 lat=5",
                     out_sign, out_exp, out_fract, out_ovf, out_unf, out_zero, lat);
        end
        consume();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_carry();
        test_align();
        test_norm_left();
        test_overflow_zero();
        test_underflow();
        test_saturate_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
